// File: rtl/delay_tune_pkg.sv
// rtl/delay_tune_pkg.sv - shared state encoding and code width for the delay tuner
package delay_tune_pkg;

  localparam int DLY_CODE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_LOCK,
    ST_FAIL
  } state_t;

endpackage

// File: rtl/early_vote.sv
// rtl/early_vote.sv - counts early=1 samples over one sample window and flags a majority
module early_vote #(
  parameter int SAMPLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic early,
  output logic majority
);

  logic [3:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 4'd0;
    end else if (clr) begin
      count <= 4'd0;
    end else if (en && early) begin
      count <= count + 4'd1;
    end
  end

  assign majority = (count > 4'(SAMPLES / 2));

endmodule

// File: rtl/delay_tune_fsm.sv
// rtl/delay_tune_fsm.sv - sweeps the delay code upward until the phase detector stops
// reporting early, then locks that code; manual override and abort supported
module delay_tune_fsm
  import delay_tune_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLES       = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cal_start,
  input  logic                  early,
  input  logic                  manual_en,
  input  logic [DLY_CODE_W-1:0] manual_sel,
  output logic [DLY_CODE_W-1:0] delay_sel,
  output logic [DLY_CODE_W-1:0] lock_code,
  output logic                  cal_busy,
  output logic                  cal_done,
  output logic                  cal_fail
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLES - 1);
  localparam logic [DLY_CODE_W-1:0] CODE_MAX = '1;

  state_t                state;
  logic [DLY_CODE_W-1:0] code;
  logic [7:0]            cnt;
  logic                  vote_clr;
  logic                  vote_en;
  logic                  majority;

  assign vote_clr = (state == ST_SETTLE);
  assign vote_en  = (state == ST_SAMPLE);

  early_vote #(
    .SAMPLES (SAMPLES)
  ) u_vote (
    .clk      (clk),
    .rst      (rst),
    .clr      (vote_clr),
    .en       (vote_en),
    .early    (early),
    .majority (majority)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      code      <= '0;
      cnt       <= 8'd0;
      delay_sel <= '0;
      lock_code <= '0;
      cal_busy  <= 1'b0;
      cal_done  <= 1'b0;
      cal_fail  <= 1'b0;
    end else begin
      delay_sel <= manual_en ? manual_sel : code;
      cal_done  <= 1'b0;
      // cal_busy is only high in SETTLE/SAMPLE/EVAL, so it doubles as "abortable"
      if (cal_busy && manual_en) begin
        state    <= ST_IDLE;
        cnt      <= 8'd0;
        cal_busy <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cal_start && !manual_en) begin
              state    <= ST_SETTLE;
              code     <= '0;
              cnt      <= 8'd0;
              cal_busy <= 1'b1;
              cal_fail <= 1'b0;
            end else begin
              code <= lock_code;
            end
          end
          ST_SETTLE: begin
            if (cnt == SETTLE_LAST) begin
              cnt   <= 8'd0;
              state <= ST_SAMPLE;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          ST_SAMPLE: begin
            if (cnt == SAMPLE_LAST) begin
              cnt   <= 8'd0;
              state <= ST_EVAL;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          ST_EVAL: begin
            if (!majority) begin
              state     <= ST_LOCK;
              lock_code <= code;
              cal_done  <= 1'b1;
              cal_busy  <= 1'b0;
            end else if (code == CODE_MAX) begin
              state    <= ST_FAIL;
              cal_fail <= 1'b1;
              cal_busy <= 1'b0;
            end else begin
              code  <= code + 1'b1;
              state <= ST_SETTLE;
            end
          end
          ST_LOCK, ST_FAIL: state <= ST_IDLE;
          default:          state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_delay_tune_fsm.sv
// tb/tb_delay_tune_fsm.sv - directed and randomized sweeps against a per-code vote model
module tb_delay_tune_fsm;

  localparam int SETTLE = 8;
  localparam int SAMP   = 5;
  localparam int PER    = SETTLE + SAMP + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       cal_start;
  logic       early;
  logic       manual_en;
  logic [3:0] manual_sel;
  logic [3:0] delay_sel;
  logic [3:0] lock_code;
  logic       cal_busy;
  logic       cal_done;
  logic       cal_fail;

  int total = 0;
  int bad   = 0;
  int ones[16];
  int res_t;
  logic res_fail;
  int exp_lock;

  delay_tune_fsm #(
    .SETTLE_CYCLES (SETTLE),
    .SAMPLES       (SAMP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cal_start  (cal_start),
    .early      (early),
    .manual_en  (manual_en),
    .manual_sel (manual_sel),
    .delay_sel  (delay_sel),
    .lock_code  (lock_code),
    .cal_busy   (cal_busy),
    .cal_done   (cal_done),
    .cal_fail   (cal_fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] make_mask(input int n);
    logic [4:0] m = 5'd0;
    while ($countones(m) < n) m[$urandom % 5] = 1'b1;
    return m;
  endfunction

  // Drives one sweep; cycle t after acceptance belongs to code t/PER, samples at phases SETTLE..SETTLE+SAMP-1
  task automatic run_sweep(input int stop_t, input int extra_t);
    logic [4:0] mask = 5'd0;
    int code;
    int ph;
    res_t    = -1;
    res_fail = 1'b0;
    @(negedge clk);
    cal_start = 1'b1;
    @(posedge clk);
    #1;
    cal_start = 1'b0;
    chk("accept_busy", cal_busy, 1);
    chk("accept_fail_clr", cal_fail, 0);
    for (int t = 0; t < 17 * PER; t++) begin
      code = t / PER;
      ph   = t % PER;
      if (ph == 0) mask = make_mask(ones[code > 15 ? 15 : code]);
      if (stop_t >= 0 && t == stop_t) begin
        cal_start = 1'b0;
        return;
      end
      if (ph >= SETTLE && ph < SETTLE + SAMP) early = mask[ph - SETTLE];
      else early = 1'($urandom % 2);
      cal_start = (t == extra_t);
      @(posedge clk);
      #1;
      if (cal_done) begin res_t = t + 1; break; end
      if (cal_fail) begin res_t = t + 1; res_fail = 1'b1; break; end
    end
    cal_start = 1'b0;
    early     = 1'b0;
  endtask

  task automatic sweep_expect(input string tag);
    int k = -1;
    for (int c = 0; c < 16; c++) begin
      if (k < 0 && ones[c] <= SAMP / 2) k = c;
    end
    if (k >= 0) begin
      chk({tag, "_lock_time"}, res_t, (k + 1) * PER);
      chk({tag, "_lock_code"}, lock_code, k);
      chk({tag, "_delay_sel"}, delay_sel, k);
      chk({tag, "_busy_low"}, cal_busy, 0);
      chk({tag, "_no_fail"}, cal_fail, 0);
      exp_lock = k;
      @(posedge clk);
      #1;
      chk({tag, "_done_1cyc"}, cal_done, 0);
    end else begin
      chk({tag, "_fail_flag"}, res_fail, 1);
      chk({tag, "_fail_time"}, res_t, 16 * PER);
      chk({tag, "_fail_sel15"}, delay_sel, 15);
      chk({tag, "_fail_lock"}, lock_code, exp_lock);
      chk({tag, "_fail_nodone"}, cal_done, 0);
      @(posedge clk);
      #1;
      chk({tag, "_no_wrap"}, delay_sel, 15);
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_idle_reload"}, delay_sel, exp_lock);
      chk({tag, "_fail_sticky"}, cal_fail, 1);
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    cal_start  = 1'b0;
    early      = 1'b0;
    manual_en  = 1'b0;
    manual_sel = 4'd0;
    exp_lock   = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_delay_sel", delay_sel, 0);
    chk("rst_lock_code", lock_code, 0);
    chk("rst_busy", cal_busy, 0);
    chk("rst_done", cal_done, 0);
    chk("rst_fail", cal_fail, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int c = 0; c < 16; c++) ones[c] = (c < 6) ? 5 : 0;
    run_sweep(-1, -1);
    sweep_expect("lock6");

    for (int c = 0; c < 16; c++) ones[c] = 5;
    run_sweep(-1, 30);
    sweep_expect("allearly");

    for (int c = 0; c < 16; c++) ones[c] = 0;
    run_sweep(-1, -1);
    sweep_expect("lock0");

    for (int c = 0; c < 16; c++) ones[c] = (c < 3) ? 5 : (c == 3 ? 2 : 0);
    run_sweep(-1, -1);
    sweep_expect("noisy3");

    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 16; c++)
        ones[c] = ($urandom % 4 == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 5));
      run_sweep(-1, -1);
      sweep_expect($sformatf("rand%0d", r));
    end

    for (int c = 0; c < 16; c++) ones[c] = 5;
    run_sweep(30, -1);
    manual_en  = 1'b1;
    manual_sel = 4'd9;
    @(posedge clk);
    #1;
    chk("abort_sel9", delay_sel, 9);
    chk("abort_busy", cal_busy, 0);
    chk("abort_nodone", cal_done, 0);
    chk("abort_lock", lock_code, exp_lock);
    chk("abort_fail", cal_fail, 0);
    @(negedge clk);
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("manual_ignore_start", cal_busy, 0);
    chk("manual_hold_sel", delay_sel, 9);
    manual_en = 1'b0;
    @(posedge clk);
    #1;
    chk("manual_release_sel", delay_sel, exp_lock);

    for (int c = 0; c < 16; c++) ones[c] = 5;
    run_sweep(4 * PER + 3, -1);
    rst = 1'b1;
    #1;
    chk("mid_rst_sel", delay_sel, 0);
    chk("mid_rst_lock", lock_code, 0);
    chk("mid_rst_busy", cal_busy, 0);
    chk("mid_rst_done", cal_done, 0);
    chk("mid_rst_fail", cal_fail, 0);
    @(negedge clk);
    rst      = 1'b0;
    exp_lock = 0;
    early    = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_idle", cal_busy, 0);
    chk("post_rst_sel", delay_sel, 0);
    early = 1'b0;

    for (int c = 0; c < 16; c++) ones[c] = (c < 2) ? 4 : 1;
    run_sweep(-1, -1);
    sweep_expect("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/delay_tune_fsm.md
DELAY_TUNE_FSM -- requirements
Module: delay_tune_fsm

Interface
REQ-001 Parameter SETTLE_CYCLES, default 8, SHALL set the number of wait cycles after each code change before sampling (range 1..255).
REQ-002 Parameter SAMPLES, default 5, SHALL set the number of `early` samples per code (odd, range 1..15).
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL change only on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-005 Port cal_start, input, 1 bit, SHALL request a calibration sweep (single-cycle pulse, level tolerated).
REQ-006 Port early, input, 1 bit, SHALL be the clk-synchronous phase-detector result: 1 means the delayed edge precedes the reference.
REQ-007 Port manual_en, input, 1 bit, SHALL select manual code override.
REQ-008 Port manual_sel, input, 4 bits, SHALL be the override code.
REQ-009 Port delay_sel, output, 4 bits, SHALL drive the variable-delay cell select input.
REQ-010 Port lock_code, output, 4 bits, SHALL hold the last successfully locked code.
REQ-011 Port cal_busy, output, 1 bit, SHALL be high while a sweep is in progress.
REQ-012 Port cal_done, output, 1 bit, SHALL pulse high for exactly one cycle on successful lock.
REQ-013 Port cal_fail, output, 1 bit, SHALL be a sticky flag, set when no code met the criterion and cleared by the next accepted cal_start.

Function
REQ-014 The FSM SHALL have the states IDLE, SETTLE, SAMPLE, EVAL, LOCK and FAIL.
REQ-015 IDLE -> SETTLE SHALL occur on cal_start=1 with manual_en=0; the internal code SHALL be set to 0, cal_busy set to 1 and cal_fail cleared in the same edge.
REQ-016 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-017 SAMPLE SHALL last exactly SAMPLES cycles and count the cycles with early=1 (count width 4 bits).
REQ-018 In EVAL (1 cycle), if count > SAMPLES/2 (integer division) and code < 15, the FSM SHALL set code = code+1 and go to SETTLE.
REQ-019 In EVAL, if count <= SAMPLES/2, the FSM SHALL go to LOCK and lock_code SHALL take the current code.
REQ-020 In EVAL, if count > SAMPLES/2 and code = 15, the FSM SHALL go to FAIL; the code SHALL stay at 15 and SHALL never wrap to 0.
REQ-021 LOCK SHALL assert cal_done for 1 cycle, deassert cal_busy, and return to IDLE.
REQ-022 FAIL SHALL set cal_fail, deassert cal_busy, leave lock_code unchanged, and return to IDLE.
REQ-023 delay_sel SHALL be registered; it SHALL equal manual_sel when manual_en=1, otherwise the internal code, with 1-cycle latency from either source.
REQ-024 In IDLE with manual_en=0, the internal code SHALL equal lock_code.
REQ-025 cal_start SHALL be ignored while cal_busy=1 or manual_en=1.
REQ-026 manual_en rising during a sweep SHALL abort the sweep to IDLE next cycle: cal_busy=0, no cal_done, cal_fail and lock_code unchanged.
REQ-027 Sweep length for lock at code k SHALL be (k+1)*(SETTLE_CYCLES+SAMPLES+1) cycles from cal_start acceptance to the LOCK state.

Reset
REQ-028 Asserting rst SHALL asynchronously force state IDLE, the internal code to 0, delay_sel=0, lock_code=0, cal_busy=0, cal_done=0, cal_fail=0, and all counters to 0.
REQ-029 rst asserted mid-sweep SHALL discard the sweep; after release the block SHALL wait in IDLE for a new cal_start.

Structure
REQ-030 Package delay_tune_pkg SHALL hold the FSM state enum and the constant DLY_CODE_W=4.
REQ-031 Sub-module early_vote SHALL contain the SAMPLES-cycle early counter and the majority compare, with clear/enable inputs driven by the FSM.

Verification
REQ-032 early tied to 1 for codes 0..5 and 0 from code 6, defaults: lock_code=6, delay_sel=6, one cal_done pulse, lock 98 cycles after acceptance.
REQ-033 early tied to 1: cal_fail=1, delay_sel=15, lock_code unchanged, cal_done never pulses, no wrap to 0.
REQ-034 early=0 from the start: lock_code=0 after 14 cycles, cal_done pulses once.
REQ-035 Noisy early with 2-of-5 ones at code 3 (ones otherwise below code 3): lock at 3 by majority.
REQ-036 manual_en=1 with manual_sel=9 mid-sweep: abort, delay_sel=9 next cycle; a cal_start while manual_en=1 is ignored.
REQ-037 rst pulse mid-sweep at code 4: all outputs 0 immediately and a new cal_start is required.
